// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux, request/ready handshake to
// instruction memory, one-entry fetch buffer and IR decode. Optional macro FETCH_MISALIGN_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] IR,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm16,
    output logic        fetch_valid,
    output logic        fetch_stall,
`ifdef FETCH_MISALIGN_EN
    output logic        misalign,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {S_FETCH, S_FULL, S_WAITPC, S_HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] buf_reg, buf_next;
    logic [31:0] pc4, npc;
    logic        npc_bad;
    logic        halt_on_pc;

    assign pc4 = pc_reg + 32'd4;

    // Jump target is built from the IR currently held, not the one being loaded.
    always_comb begin
        npc = pc4;
        unique case (PCSrc)
            2'b00: npc = pc4;
            2'b01: npc = pc4 + {imm_ext[29:0], 2'b00};
            2'b10: npc = jr_target;
            2'b11: npc = {pc4[31:28], ir_reg[25:0], 2'b00};
        endcase
    end

`ifdef FETCH_MISALIGN_EN
    assign npc_bad = (npc[1:0] != 2'b00);
`else
    assign npc_bad = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        buf_next   = buf_reg;
        halt_on_pc = 1'b0;
        unique case (state_reg)
            S_FETCH: begin
                // A PC update squashes the outstanding request, even if ready arrives now.
                if (PCWre) begin
                    pc_next    = npc;
                    halt_on_pc = npc_bad;
                    state_next = npc_bad ? S_HALT : S_FETCH;
                end else if (imem_ready) begin
                    buf_next   = imem_rdata;
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (PCWre) begin
                    pc_next    = npc;
                    halt_on_pc = npc_bad;
                end
                if (IRWre) begin
                    ir_next = buf_reg;
                    if (buf_reg[31:26] == HALT_OP)
                        state_next = S_HALT;
                    else if (PCWre)
                        state_next = npc_bad ? S_HALT : S_FETCH;
                    else
                        state_next = S_WAITPC;
                end else if (PCWre) begin
                    buf_next   = 32'd0;
                    state_next = npc_bad ? S_HALT : S_FETCH;
                end
            end
            S_WAITPC: begin
                if (PCWre) begin
                    pc_next    = npc;
                    halt_on_pc = npc_bad;
                    state_next = npc_bad ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= 32'd0;
            buf_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            buf_reg   <= buf_next;
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic misalign_reg;
    always_ff @(posedge CLK) begin
        if (RST)
            misalign_reg <= 1'b0;
        else if (halt_on_pc)
            misalign_reg <= 1'b1;
    end
    assign misalign = misalign_reg;
`else
    logic unused_halt_on_pc;
    assign unused_halt_on_pc = halt_on_pc;
`endif

    assign imem_req    = (state_reg == S_FETCH);
    assign imem_addr   = pc_reg;
    assign PC          = pc_reg;
    assign PC4         = pc4;
    assign IR          = ir_reg;
    assign op          = ir_reg[31:26];
    assign rs          = ir_reg[25:21];
    assign rt          = ir_reg[20:16];
    assign rd          = ir_reg[15:11];
    assign sa          = ir_reg[10:6];
    assign func        = ir_reg[5:0];
    assign imm16       = ir_reg[15:0];
    assign fetch_valid = (state_reg == S_FULL);
    assign halted      = (state_reg == S_HALT);
    assign fetch_stall = IRWre && !RST &&
                         ((state_reg == S_FETCH) || (state_reg == S_WAITPC));

endmodule
